// File: rtl/pulse_credit_tx.sv
// -----------------------------------------------------------------------------
// pulse_credit_tx
//
// Transmit-side pacing stage for a toggle-based pulse synchronizer (clk_a
// domain). Raw event strobes are counted into a saturating pending counter and
// released one single-cycle pulse at a time. After each pulse the block waits
// for the receiver's acknowledge toggle (synchronized into clk_a) or for a
// timeout. It then holds a minimum idle gap before the next release.
//
// Ports
//   clk_a        in   transmit-domain clock, rising edge
//   rst          in   synchronous active-high reset
//   evt_in       in   event strobe, one event per high cycle
//   ack_tgl      in   acknowledge toggle from clk_b (asynchronous to clk_a)
//   err_clr      in   clears the overflow / timeout_err sticky flags
//   pulse_out    out  single-cycle pulse to the downstream synchronizer
//   busy         out  high whenever the pacing FSM is not idle
//   pending      out  number of queued events
//   overflow     out  sticky: an event was dropped at saturation
//   timeout_err  out  sticky: a wait ended by timeout instead of an ack
//
// Parameter constraints: TIMEOUT >= 2, MIN_GAP >= 1,
//                        2**TO_W > max(TIMEOUT, MIN_GAP).
// -----------------------------------------------------------------------------
module pulse_credit_tx #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 32,
  parameter int MIN_GAP = 2,
  parameter int TO_W    = 6
) (
  input  logic             clk_a,
  input  logic             rst,
  input  logic             evt_in,
  input  logic             ack_tgl,
  input  logic             err_clr,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  GAP_LAST = TO_W'(MIN_GAP - 1);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;        // shared WAIT / GAP cycle counter
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             to_err_q, to_err_d;

  // ack_s1 is the metastability-catching stage; only ack_s2 and ack_d are
  // used by logic.
  logic ack_s1_q, ack_s2_q, ack_d_q;
  logic ack_edge;

  logic inc, dec;
  logic ovf_set, to_set;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      to_err_q <= 1'b0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      ack_d_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      to_err_q <= to_err_d;
      ack_s1_q <= ack_tgl;
      ack_s2_q <= ack_s1_q;
      ack_d_q  <= ack_s2_q;
    end
  end

  // ack_d follows ack_s2 every cycle, so each toggle is a one-cycle edge.
  assign ack_edge = ack_s2_q ^ ack_d_q;

  // ---------------------------------------------------------------------------
  // Pacing FSM: next state, shared counter, timeout detection
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_set  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q != '0) state_d = S_SEND;
      end

      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // An ack in the last wait cycle still counts as an ack, not a timeout.
        if (ack_edge) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == TO_LAST) begin
          to_set  = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending counter and sticky flags
  // ---------------------------------------------------------------------------
  assign inc = evt_in;
  assign dec = (state_q == S_SEND);

  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;

    if (inc && !dec) begin
      if (pend_q == PEND_MAX) ovf_set = 1'b1;
      else                    pend_d  = pend_q + 1'b1;
    end else if (dec && !inc) begin
      // SEND is only entered with a non-zero count; the guard keeps the
      // counter from wrapping even if that invariant were ever broken.
      if (pend_q != '0) pend_d = pend_q - 1'b1;
    end
  end

  // A set condition in the same cycle as err_clr leaves the flag set.
  assign ovf_d    = ovf_set | (ovf_q    & ~err_clr);
  assign to_err_d = to_set  | (to_err_q & ~err_clr);

  // ---------------------------------------------------------------------------
  // Outputs: decoded straight from registered state, no extra latency
  // ---------------------------------------------------------------------------
  assign pulse_out   = (state_q == S_SEND);
  assign busy        = (state_q != S_IDLE);
  assign pending     = pend_q;
  assign overflow    = ovf_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_pulse_credit_tx.sv
// -----------------------------------------------------------------------------
// tb_pulse_credit_tx
//
// Directed stimulus for pulse_credit_tx with a timeline-based reference model
// (pulse times, wait windows and idle times tracked as cycle stamps) compared
// against the DUT on every cycle, plus hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_pulse_credit_tx;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 32;
  localparam int MIN_GAP = 2;
  localparam int TO_W    = 6;
  localparam int PMAX    = (1 << CNT_W) - 1;
  localparam int BIG     = 1 << 30;

  logic             clk_a   = 1'b0;
  logic             rst     = 1'b0;
  logic             evt_in  = 1'b0;
  logic             ack_tgl = 1'b0;
  logic             err_clr = 1'b0;
  logic             pulse_out;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             timeout_err;

  pulse_credit_tx #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .MIN_GAP(MIN_GAP),
    .TO_W   (TO_W)
  ) dut (
    .clk_a      (clk_a),
    .rst        (rst),
    .evt_in     (evt_in),
    .ack_tgl    (ack_tgl),
    .err_clr    (err_clr),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk_a = ~clk_a;

  // ---------------------------------------------------------------------------
  // Counters (model compare process and directed checks kept separate)
  // ---------------------------------------------------------------------------
  int n_vec_m = 0, n_err_m = 0;
  int n_vec_d = 0, n_err_d = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec_d++;
    if (act !== exp) begin
      n_err_d++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Cycle c is the interval after rising edge c.
  //   - a pulse occurs in the first cycle after an idle cycle with work queued
  //   - the wait window is the TIMEOUT cycles after the pulse, cut short by a
  //     visible ack edge; the block is idle again MIN_GAP cycles later
  //   - the ack edge visible in a cycle is the change between the ack levels
  //     sampled two and three edges earlier (reset samples count as 0)
  // ---------------------------------------------------------------------------
  int cyc = 0;
  bit m_valid = 1'b0;
  int m_pend, m_pulse_cyc, m_idle_at;
  bit m_ovf, m_to, m_wait;
  bit h_q, g_q, g_prev;
  bit mp_prev_pulse, mp_prev_idle, mp_edge, mp_ovf_set, mp_to_set;
  int mp_prev_pend;

  always @(posedge clk_a) begin
    cyc++;
    if (rst) begin
      m_valid     = 1'b1;
      m_pend      = 0;
      m_ovf       = 1'b0;
      m_to        = 1'b0;
      m_wait      = 1'b0;
      m_pulse_cyc = -BIG;
      m_idle_at   = cyc;
      h_q         = 1'b0;
      g_q         = 1'b0;
      g_prev      = 1'b0;
    end else if (m_valid) begin
      mp_prev_pulse = (m_pulse_cyc == cyc - 1);
      mp_prev_idle  = (cyc - 1 >= m_idle_at);
      mp_prev_pend  = m_pend;
      mp_edge       = g_q ^ g_prev;
      mp_ovf_set    = 1'b0;
      mp_to_set     = 1'b0;

      if (m_wait) begin
        if (mp_edge) begin
          m_wait    = 1'b0;
          m_idle_at = cyc + MIN_GAP;
        end else if (cyc - 1 - m_pulse_cyc == TIMEOUT) begin
          m_wait    = 1'b0;
          m_idle_at = cyc + MIN_GAP;
          mp_to_set = 1'b1;
        end
      end
      if (mp_prev_pulse) m_wait = 1'b1;
      if (mp_prev_idle && mp_prev_pend > 0) begin
        m_pulse_cyc = cyc;
        m_idle_at   = BIG;
      end

      if (evt_in && !mp_prev_pulse) begin
        if (mp_prev_pend == PMAX) mp_ovf_set = 1'b1;
        else                      m_pend     = mp_prev_pend + 1;
      end else if (!evt_in && mp_prev_pulse) begin
        m_pend = mp_prev_pend - 1;
      end

      m_ovf = mp_ovf_set | (m_ovf & !err_clr);
      m_to  = mp_to_set  | (m_to  & !err_clr);

      g_prev = g_q;
      g_q    = h_q;
      h_q    = ack_tgl;
    end
  end

  // Compare process: every cycle after the first reset.
  always @(negedge clk_a) begin
    if (m_valid) begin
      n_vec_m++;
      if (pulse_out !== (m_pulse_cyc == cyc) || busy !== (cyc < m_idle_at) ||
          pending !== CNT_W'(m_pend) || overflow !== m_ovf || timeout_err !== m_to) begin
        n_err_m++;
        $display("FAIL model cycle %0d: got pulse=%b busy=%b pend=%0d ovf=%b to=%b, expected pulse=%b busy=%b pend=%0d ovf=%b to=%b",
                 cyc, pulse_out, busy, pending, overflow, timeout_err,
                 (m_pulse_cyc == cyc), (cyc < m_idle_at), m_pend, m_ovf, m_to);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver model: toggles ack_tgl 3 cycles after each pulse when enabled;
  // stray toggles are requested by bumping stray_req.
  // ---------------------------------------------------------------------------
  bit ack_en    = 1'b0;
  int ack_cd    = 0;
  int stray_req = 0;
  int stray_done = 0;

  always @(negedge clk_a) begin
    if (stray_done != stray_req) begin
      ack_tgl    = ~ack_tgl;
      stray_done = stray_req;
    end else if (!ack_en) begin
      ack_cd = 0;
    end else if (pulse_out) begin
      ack_cd = 3;
    end else if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) ack_tgl = ~ack_tgl;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: step() samples outputs, then advances one cycle
  // ---------------------------------------------------------------------------
  int s_pulses, s_last, s_min, s_peak;

  task automatic s_reset();
    s_pulses = 0;
    s_last   = -1;
    s_min    = BIG;
    s_peak   = 0;
  endtask

  task automatic step();
    if (pulse_out === 1'b1) begin
      s_pulses++;
      if (s_last >= 0 && cyc - s_last < s_min) s_min = cyc - s_last;
      s_last = cyc;
    end
    if (int'(pending) > s_peak) s_peak = int'(pending);
    @(negedge clk_a);
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((busy !== 1'b0 || pending !== '0) && k < budget) begin
      step();
      k++;
    end
    check({name, " drained"}, (busy !== 1'b0 || pending !== '0), 0);
  endtask

  task automatic wait_timeout(input string name, input int budget);
    int k;
    k = 0;
    while (timeout_err !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check({name, " timeout_err"}, timeout_err, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " pulse"},   pulse_out,   0);
    check({name, " busy"},    busy,        0);
    check({name, " pending"}, pending,     0);
    check({name, " ovf"},     overflow,    0);
    check({name, " to_err"},  timeout_err, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int p_cyc;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk_a);
    rst = 1'b0;
    check_all_zero("reset");

    // 1: single event, ack 3 cycles after the pulse
    ack_en = 1'b1;
    s_reset();
    evt_in = 1'b1;
    step();
    evt_in = 1'b0;
    check("t1 pending cycle1", pending, 1);
    check("t1 no pulse cycle1", pulse_out, 0);
    step();
    check("t1 pulse cycle2", pulse_out, 1);
    // pulse at P, ack edge visible at P+5, GAP P+6..P+7, idle at P+8
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      step();
      k++;
    end
    check("t1 busy fall", k, 8);
    check("t1 pending end", pending, 0);
    check("t1 no timeout", timeout_err, 0);

    // 2: burst of 5 back-to-back events with acks
    s_reset();
    evt_in = 1'b1;
    step_n(5);
    evt_in = 1'b0;
    drain("t2", 300);
    check("t2 pulse count", s_pulses, 5);
    check("t2 min spacing", s_min, 1 + 5 + MIN_GAP + 1);
    check("t2 pending peak", s_peak, 4);

    // 3: 17 events, no acks: saturation, overflow, timeout
    ack_en = 1'b0;
    s_reset();
    evt_in = 1'b1;
    step_n(17);
    evt_in = 1'b0;
    check("t3 pending sat", pending, PMAX);
    check("t3 overflow", overflow, 1);
    wait_timeout("t3", 100);
    check("t3 wait length", cyc - s_last, 1 + TIMEOUT);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3 ovf cleared", overflow, 0);
    check("t3 to cleared", timeout_err, 0);
    // err_clr held across the next timeout: the set still wins
    err_clr = 1'b1;
    wait_timeout("t3 set wins", 100);
    step();
    check("t3 clr next cycle", timeout_err, 0);
    err_clr = 1'b0;
    ack_en = 1'b1;
    drain("t3", 2000);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // 4: event arriving in the SEND cycle
    s_reset();
    evt_in = 1'b1;
    step();
    evt_in = 1'b0;
    step();
    check("t4 pulse", pulse_out, 1);
    evt_in = 1'b1;
    step();
    evt_in = 1'b0;
    check("t4 pending held", pending, 1);
    drain("t4", 200);
    check("t4 pulse count", s_pulses, 2);

    // 5: stray ack while idle is ignored; the pulse times out
    ack_en = 1'b0;
    s_reset();
    stray_req++;
    step_n(6);
    evt_in = 1'b1;
    step();
    evt_in = 1'b0;
    step();
    check("t5 pulse", pulse_out, 1);
    wait_timeout("t5", 100);
    check("t5 wait length", cyc - s_last, 1 + TIMEOUT);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    drain("t5", 100);

    // 6: reset mid-WAIT with pending=3, then a late ack
    evt_in = 1'b1;
    step_n(4);
    evt_in = 1'b0;
    check("t6 pending 3", pending, 3);
    step_n(5);
    check("t6 busy in wait", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("t6 after rst");
    s_reset();
    stray_req++;
    step_n(40);
    check("t6 no pulse", s_pulses, 0);
    check("t6 idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec_m + n_vec_d, n_err_m + n_err_d);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pulse_credit_tx.md
Name: pulse_credit_tx

Overview:
- Transmit-side pacing stage in the clk_a domain. It sits directly upstream of the toggle-based pulse synchronizer and drives that synchronizer's single-cycle pulse input.
- Raw event strobes may arrive back-to-back, faster than the clk_b side can resolve. The block queues them in a saturating pending counter.
- Events are released one pulse at a time. The next pulse is released only after the receiver returns an acknowledge toggle, which is synchronized back into clk_a, or after a timeout. A minimum gap is then enforced.

Parameters:
- CNT_W, 4: width of the pending-event counter. Maximum queued events is 2^CNT_W-1.
- TIMEOUT, 32: clk_a cycles to wait in WAIT for an ack edge before abandoning the wait. Must be ≥ 2.
- MIN_GAP, 2: idle clk_a cycles held in GAP after each pulse completes. Must be ≥ 1.
- TO_W, 6: width of the shared wait/gap counter. Must satisfy 2^TO_W > max(TIMEOUT, MIN_GAP).

Ports:
- clk_a  in  1  transmit-domain clock; all logic is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset, clk_a domain.
- evt_in  in  1  event strobe; each high cycle is one event.
- ack_tgl  in  1  acknowledge level from the clk_b domain; toggles once per received pulse. Asynchronous to clk_a.
- err_clr  in  1  clears the overflow and timeout_err sticky flags.
- pulse_out  out  1  single-cycle pulse to the downstream toggle synchronizer.
- busy  out  1  high whenever state ≠ IDLE.
- pending  out  CNT_W  current queued event count.
- overflow  out  1  sticky: an event was dropped because the counter was saturated.
- timeout_err  out  1  sticky: a WAIT ended by timeout rather than by an ack.

Behaviour:
- Reset (rst high at a clk_a edge): all of the following clear, and any pulse in flight or queued count is discarded:
  - state=IDLE; pending=0; pulse_out=0; busy=0; overflow=0; timeout_err=0.
  - wait/gap counter=0.
  - ack_s1, ack_s2 and ack_d are each loaded with 0.
- Ack synchronizer and edge detect:
  - ack_tgl passes through two flops, ack_s1 then ack_s2, followed by ack_d.
  - ack_edge = ack_s2 XOR ack_d.
  - ack_d updates every cycle, so each ack edge is visible for exactly one cycle.
  - An ack_edge in any state other than WAIT is discarded, with no flag raised.
- Pending counter (registered):
  - inc = evt_in; dec = (state==SEND).
  - inc and dec together: count unchanged.
  - inc only, count < max: +1.
  - inc only, count == max: count holds and overflow sets on the next edge.
  - dec only: −1. dec is only possible when count > 0.
  - Never wraps in either direction.
- FSM (registered state, one transition per edge):
  - IDLE: if pending > 0, go to SEND.
  - SEND: one cycle. pulse_out=1, decoded as state==SEND, so there is no extra latency. Load counter=0, go to WAIT.
  - WAIT: counter increments each cycle.
    - If ack_edge, go to GAP and load counter=0.
    - Else if counter == TIMEOUT−1, set timeout_err, go to GAP and load counter=0.
    - If ack_edge and timeout coincide, ack wins and timeout_err is not set.
  - GAP: counter increments. When counter == MIN_GAP−1, go to IDLE.
- Latency:
  - evt_in high in cycle 0 with pending=0 and IDLE gives pending=1 in cycle 1 and pulse_out in cycle 2.
  - Minimum pulse-to-pulse spacing is 1 (SEND) + WAIT length + MIN_GAP + 1 (IDLE) cycles.
- pulse_out is never high in two consecutive cycles.
- busy = (state ≠ IDLE).
- Sticky flags:
  - err_clr clears overflow and timeout_err.
  - If a set condition and err_clr occur in the same cycle, the set wins.
- Reset mid-WAIT: the block returns to IDLE. Any ack arriving later is discarded by the non-WAIT rule, after ack_d has resynchronized.

Test Plan (CNT_W=4, TIMEOUT=32, MIN_GAP=2, unless stated otherwise):
- Single event, receiver model toggles ack_tgl 3 cycles after pulse_out:
  - pulse_out high in exactly cycle 2 after evt_in.
  - busy falls after GAP.
  - pending returns to 0.
  - timeout_err stays 0.
- Burst of 5 back-to-back evt_in cycles with the ack model active:
  - pending peaks at 5 (4 if SEND overlaps).
  - Exactly 5 single-cycle pulses occur, each spaced by at least WAIT+4 cycles.
  - pending ends at 0.
- 17 consecutive evt_in cycles with ack_tgl held constant:
  - pending saturates at 15 and overflow=1.
  - The first pulse times out after 32 WAIT cycles and timeout_err=1.
  - err_clr clears both flags.
- evt_in asserted in the same cycle as SEND: pending is unchanged in that cycle, and the count of pulses equals the count of events.
- ack_tgl toggled while IDLE, then one event issued: the stray ack is ignored, and the pulse waits for a fresh ack edge or the timeout.
- rst asserted mid-WAIT with pending=3:
  - All outputs are 0 next cycle.
  - No further pulse_out occurs without new events.
  - A late ack edge causes no state change.
